vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Display timing generator in the 25.2 MHz pixel-clock domain (PLL clk0_out, 24 MHz x21/20).
//   Consumes PLL extlock and holds the display idle until lock is stable.
//   Then produces hsync/vsync/de and pixel coordinates for the renderer and VGA pins.
//   Restarts cleanly whenever lock is lost.
// PARAMETERS
//   H_ACTIVE 640  visible pixels/line;  H_FP 16  h front porch;  H_SYNC 96  h sync width;  H_BP 48  h back porch
//   V_ACTIVE 480  visible lines/frame;  V_FP 10  v front porch;  V_SYNC 2  v sync width;   V_BP 33  v back porch
//   SYNC_POL 0    0 = hsync/vsync active-low, 1 = active-high
//   LOCK_WAIT 1024  cycles synchronised lock must stay high before timing starts (>=1)
//   CW 10         width of x/y and internal counters
// PORTS
//   clk          in   1   pixel clock (PLL clk0_out)
//   reset        in   1   synchronous, active-high reset
//   pll_lock     in   1   PLL extlock, asynchronous to clk
//   hsync        out  1   horizontal sync, polarity per SYNC_POL
//   vsync        out  1   vertical sync, polarity per SYNC_POL
//   de           out  1   data enable; 1 in the visible region only
//   x            out  CW  pixel column when de=1, else 0
//   y            out  CW  pixel row when de=1, else 0
//   line_start   out  1   1-cycle pulse at h=0 of every line (incl. blanking lines)
//   frame_start  out  1   1-cycle pulse at h=0, v=0
//   running      out  1   1 while in RUN state
// BEHAVIOUR
//   Reset values (all outputs registered):
//     hsync = vsync = ~SYNC_POL (inactive); de, x, y, line_start, frame_start, running = 0.
//     FSM in WAIT_LOCK; counters and synchroniser cleared.
//   pll_lock passes through a 2-flop synchroniser -> lk.
//   FSM:
//     WAIT_LOCK: lk=1 -> SETTLE with settle count = 0.
//     SETTLE: count increments each cycle lk=1; lk=0 -> WAIT_LOCK (count discarded).
//       count reaches LOCK_WAIT-1 -> RUN with h=v=0.
//     RUN: lk=0 -> WAIT_LOCK next cycle; counters cleared; outputs return to reset values on that edge.
//   Start latency: pll_lock sampled high at edge N and held -> running=1, de=1, x=0, y=0,
//     frame_start=1, line_start=1 all on edge N+LOCK_WAIT+2.
//   Counters (RUN only):
//     h: 0..HT-1 with HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
//     v: 0..VT-1 with VT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//     v increments when h wraps HT-1 -> 0; v wraps VT-1 -> 0 in the same cycle.
//   Outputs for the cycle presenting position (h,v), evaluated combinationally then registered:
//     de = h<H_ACTIVE && v<V_ACTIVE; x = de ? h : 0; y = de ? v : 0.
//     hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
//     vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491); vsync is line-aligned, changing at h=0.
//   Frame = HT*VT = 420000 cycles; exactly one frame_start per frame.
//   reset has priority over lock; reset mid-frame returns everything to reset values on the next edge.
//   No arithmetic overflow: CW must hold max(HT,VT)-1; counters never exceed HT-1/VT-1.
// TESTING
//   1. reset=1 for 5 cycles, pll_lock=1 -> all outputs at reset values during reset;
//      with LOCK_WAIT=4, running/frame_start/de rise 6 edges after first lock sample post-reset.
//   2. Free-run 2 full frames:
//      de=1 for exactly 307200 cycles/frame; hsync active 96 cycles/line starting at h=656;
//      vsync active for 1600 cycles; frame_start period 420000.
//   3. Line boundary: at h=639 -> x=639, de=1; at h=640 -> de=0, x=0.
//      At h=799,v=479 -> next cycle y=0? no: v=480 -> de=0 for the whole line.
//   4. Drop pll_lock for 1 cycle mid-SETTLE (LOCK_WAIT=8) -> settle restarts; running delayed by the full wait.
//   5. Drop pll_lock at v=200 in RUN -> running=0, de=0, syncs inactive within 3 edges;
//      relock -> new frame starts at x=0,y=0 with frame_start.
//   6. SYNC_POL=1 build -> hsync/vsync idle low, pulse high at the same h/v windows.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA display timing generator: waits for a stable PLL lock, then free-runs
// the h/v raster and emits registered sync, data-enable and pixel coordinates.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int LOCK_WAIT = 1024,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pll_lock,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] CNT_LAST = SW'(LOCK_WAIT - 2);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t        state, state_nx;
    logic [1:0]    sync;
    logic          lk;
    logic [SW-1:0] cnt, cnt_nx;
    logic [CW-1:0] h, v, h_nx, v_nx;
    logic          active, de_c, hs_c, vs_c;

    assign lk = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            state <= WAIT_LOCK;
            cnt   <= '0;
            h     <= '0;
            v     <= '0;
        end else begin
            sync  <= {sync[0], pll_lock};
            state <= state_nx;
            cnt   <= cnt_nx;
            h     <= h_nx;
            v     <= v_nx;
        end
    end

    // Counters sit at zero outside RUN so entry into RUN always starts at (0,0).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        h_nx     = '0;
        v_nx     = '0;
        case (state)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (lk) state_nx = (LOCK_WAIT == 1) ? RUN : SETTLE;
            end
            SETTLE: begin
                if (!lk)                  state_nx = WAIT_LOCK;
                else if (cnt == CNT_LAST) state_nx = RUN;
                else                      cnt_nx   = cnt + 1'b1;
            end
            RUN: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                end else if (h == H_LAST) begin
                    v_nx = (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h_nx = h + 1'b1;
                    v_nx = v;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // A lock loss seen in RUN idles the outputs on the same edge the FSM leaves.
    always_comb begin
        active = (state == RUN) && lk;
        de_c   = active && (h < H_VIS) && (v < V_VIS);
        hs_c   = active && (h >= HS_BEG) && (h < HS_END);
        vs_c   = active && (v >= VS_BEG) && (v < VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
            de          <= de_c;
            x           <= de_c ? h : '0;
            y           <= de_c ? v : '0;
            line_start  <= active && (h == '0);
            frame_start <= active && (h == '0) && (v == '0);
            running     <= active;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster pol0/LW4, small raster
// pol1/LW8, full 640x480 LW4) checked each cycle against a raster-position model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset, pll_lock;
    always #5 clk = ~clk;

    logic a_hs, a_vs, a_de, a_ls, a_fs, a_run; logic [9:0] a_x, a_y;
    logic b_hs, b_vs, b_de, b_ls, b_fs, b_run; logic [9:0] b_x, b_y;
    logic d_hs, d_vs, d_de, d_ls, d_fs, d_run; logic [9:0] d_x, d_y;

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(12), .V_FP(2),
        .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0), .LOCK_WAIT(4), .CW(10)) dut_a (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .running(a_run));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(12), .V_FP(2),
        .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b1), .LOCK_WAIT(8), .CW(10)) dut_b (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .running(b_run));
    vga_timing_gen #(.SYNC_POL(1'b0), .LOCK_WAIT(4), .CW(10)) dut_d (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .running(d_run));

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    // hr = consecutive post-reset edges with lock sampled high; h2 = hr two edges ago.
    int hr = 0, h1 = 0, h2 = 0;
    always @(posedge clk) begin
        if (reset) begin
            hr <= 0; h1 <= 0; h2 <= 0;
        end else begin
            hr <= pll_lock ? hr + 1 : 0;
            h1 <= hr;
            h2 <= h1;
        end
    end

    // Expected {running, frame_start, line_start, de, hsync, vsync, x, y}.
    function automatic logic [25:0] expv(input int hh, input int lw, input int ha, input int hf,
        input int hs, input int hb, input int va, input int vf, input int vs, input int vb,
        input bit pol);
        int ht, vt, t, h, v;
        logic de, hy, vy;
        if (hh < lw + 1) return {4'b0000, ~pol, ~pol, 20'd0};
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        t  = hh - (lw + 1);
        h  = t % ht;
        v  = (t / ht) % vt;
        de = (h < ha) && (v < va);
        hy = (h >= ha + hf) && (h < ha + hf + hs);
        vy = (v >= va + vf) && (v < va + vf + vs);
        return {1'b1, (h == 0 && v == 0), (h == 0), de, hy ? pol : ~pol, vy ? pol : ~pol,
                de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0};
    endfunction

    task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic lit(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut_a", {a_run, a_fs, a_ls, a_de, a_hs, a_vs, a_x, a_y},
                expv(h2, 4, 16, 4, 6, 6, 12, 2, 2, 4, 1'b0));
            chk("dut_b", {b_run, b_fs, b_ls, b_de, b_hs, b_vs, b_x, b_y},
                expv(h2, 8, 16, 4, 6, 6, 12, 2, 2, 4, 1'b1));
            chk("dut_d", {d_run, d_fs, d_ls, d_de, d_hs, d_vs, d_x, d_y},
                expv(h2, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        end
    end

    initial begin
        int la, lb, ld, lb2, kd;
        int de_cnt, vs_cnt, hs_cnt, fs_cnt, bhs_cnt;
        bit ok;
        la = -1; lb = -1; ld = -1; lb2 = -1; kd = -1;
        de_cnt = 0; vs_cnt = 0; hs_cnt = 0; fs_cnt = 0; bhs_cnt = 0;
        reset = 1'b1; pll_lock = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        lit("reset_idle", {a_run, a_de, a_hs, a_vs, b_hs, b_vs}, 6'b001100);
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // Start latency from first post-reset lock sample.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) lit("idle_pol", {a_hs, a_vs, b_hs, b_vs}, 4'b1100);
            if (a_run && la < 0) la = k - 1;
            if (d_run) begin ld = k - 1; break; end
        end
        lit("lat_a", la, 6);
        lit("lat_d", ld, 6);

        // Free run: t counts edges since dut_a/dut_d first showed running.
        for (int t = 0; t < 1400; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0)   lit("d_start", {d_fs, d_ls, d_de, d_x, d_y}, {3'b111, 20'd0});
            if (t == 639) lit("d_h639", {d_de, d_x}, {1'b1, 10'd639});
            if (t == 640) lit("d_h640", {d_de, d_x}, 11'd0);
            if (t == 655) lit("d_hs655", d_hs, 1);
            if (t == 656) lit("d_hs656", d_hs, 0);
            if (t == 751) lit("d_hs751", d_hs, 0);
            if (t == 752) lit("d_hs752", d_hs, 1);
            if (t == 800) lit("d_line1", {d_ls, d_de, d_y}, {2'b11, 10'd1});
            if (t < 640) begin de_cnt += a_de; vs_cnt += (a_vs == 1'b0); end
            if (t < 32) hs_cnt += (a_hs == 1'b0);
            if (t >= 4 && t < 36) bhs_cnt += b_hs;
            if (t < 1280) fs_cnt += a_fs;
            if (b_run && lb < 0) lb = ld + t;
        end
        lit("lat_b", lb, 10);
        lit("a_de_per_frame", de_cnt, 192);
        lit("a_vs_per_frame", vs_cnt, 64);
        lit("a_hs_per_line", hs_cnt, 6);
        lit("b_hs_high_per_line", bhs_cnt, 6);
        lit("a_fs_two_frames", fs_cnt, 2);

        // Lock glitch during dut_b settle restarts its full wait.
        pll_lock = 1'b0;
        repeat (10) @(negedge clk);
        lit("all_idle", {a_run, b_run, d_run}, 0);
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (b_run) begin lb2 = k - 1; break; end
        end
        lit("lat_b_restart", lb2, 10);

        // Lock loss mid-frame on dut_a, then relock.
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (a_de && a_y == 10'd5) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        lit("reach_row5", ok, 1);
        pll_lock = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!a_run) begin kd = k; break; end
        end
        lit("drop_latency", kd, 3);
        lit("drop_idle", {a_de, a_hs, a_vs}, 3'b011);
        pll_lock = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_run) begin ok = 1'b1; break; end
        end
        lit("relock_seen", ok, 1);
        lit("relock_frame", {a_fs, a_ls, a_x, a_y}, {2'b11, 20'd0});

        // Random lock drops, glitches and occasional resets.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 1999) == 0);
            if (pll_lock) pll_lock = ($urandom_range(0, 799) != 0);
            else          pll_lock = ($urandom_range(0, 3) == 0);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
